// File: rtl/seq_mult_param_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// The master issues requests; the slave (the multiplier) reports status and the product.
interface seq_mult_param_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/seq_mult_param.sv
// Radix-2 shift-add multiplier: one partial product per cycle into a right-shifting
// accumulator, signed (last step subtracts) or unsigned, WIDTH cycles per product.
module seq_mult_param #(
    parameter int WIDTH          = 6,
    parameter bit SIGNED_SUPPORT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seq_mult_param_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 mode_q, mode_d;
    logic [WIDTH:0]       acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     shifted;
    logic                 last_step;

    // In signed mode the multiplier's MSB carries weight -2^(W-1), hence the final subtract.
    always_comb begin
        last_step = (count_q == CW'(WIDTH - 1));
        addend    = mode_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
        if (!acc_lo_q[0]) begin
            addend = '0;
        end
        sum     = (mode_q && last_step) ? (acc_hi_q - addend) : (acc_hi_q + addend);
        shifted = {(mode_q & sum[WIDTH]), sum, acc_lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        mode_d    = mode_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    mcand_d  = bus.a;
                    mode_d   = bus.signed_mode & SIGNED_SUPPORT;
                    acc_hi_d = '0;
                    acc_lo_d = bus.b;
                    count_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_hi_d = shifted[2*WIDTH:WIDTH];
                acc_lo_d = shifted[WIDTH-1:0];
                if (last_step) begin
                    state_d   = DONE;
                    product_d = shifted[2*WIDTH-1:0];
                    count_d   = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mode_q    <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            mode_q    <= mode_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            product_q <= product_d;
        end
    end

    assign bus.ready   = (state_q != CALC);
    assign bus.busy    = (state_q == CALC);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Directed and randomised checks of seq_mult_param at several widths; expected products
// are queued when an operation is issued and compared when the matching done pulse appears.
module tb_seq_mult_param;
    logic clk;
    logic rst;

    int n_cmp;
    int n_fail;

    logic [15:0] q6[$];
    logic [15:0] qu[$];
    logic [15:0] q4[$];
    logic [15:0] q8[$];

    seq_mult_param_if #(.WIDTH(6)) bus6 ();
    seq_mult_param_if #(.WIDTH(6)) busu ();
    seq_mult_param_if #(.WIDTH(4)) bus4 ();
    seq_mult_param_if #(.WIDTH(8)) bus8 ();

    seq_mult_param #(.WIDTH(6), .SIGNED_SUPPORT(1'b1)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));
    seq_mult_param #(.WIDTH(6), .SIGNED_SUPPORT(1'b0)) u_dutu (.clk(clk), .rst(rst), .bus(busu));
    seq_mult_param #(.WIDTH(4), .SIGNED_SUPPORT(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_mult_param #(.WIDTH(8), .SIGNED_SUPPORT(1'b1)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference product, computed arithmetically and truncated to 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input bit sgn, input logic [7:0] a, input logic [7:0] b);
        longint ai, bi, mask;
        mask = (longint'(1) << w) - 1;
        ai   = longint'(a) & mask;
        bi   = longint'(b) & mask;
        if (sgn && ai[w-1]) ai = ai - (longint'(1) << w);
        if (sgn && bi[w-1]) bi = bi - (longint'(1) << w);
        return 16'((ai * bi) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return bus6.done;
            1:       return busu.done;
            2:       return bus4.done;
            default: return bus8.done;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return bus6.busy;
            1:       return busu.busy;
            2:       return bus4.busy;
            default: return bus8.busy;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return bus6.ready;
            1:       return busu.ready;
            2:       return bus4.ready;
            default: return bus8.ready;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every done pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        logic [15:0] e;
        #1;
        if (bus6.done === 1'b1) begin
            if (q6.size() == 0) checkOutput("w6 done without pending op", 16'(q6.size()), 16'd1);
            else begin e = q6.pop_front(); checkOutput("w6 product", 16'(bus6.product), e); end
        end
        if (busu.done === 1'b1) begin
            if (qu.size() == 0) checkOutput("w6u done without pending op", 16'(qu.size()), 16'd1);
            else begin e = qu.pop_front(); checkOutput("w6u product", 16'(busu.product), e); end
        end
        if (bus4.done === 1'b1) begin
            if (q4.size() == 0) checkOutput("w4 done without pending op", 16'(q4.size()), 16'd1);
            else begin e = q4.pop_front(); checkOutput("w4 product", 16'(bus4.product), e); end
        end
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) checkOutput("w8 done without pending op", 16'(q8.size()), 16'd1);
            else begin e = q8.pop_front(); checkOutput("w8 product", 16'(bus8.product), e); end
        end
    end

    // Drives one request for a single cycle, queues its expected product, then scrambles operands.
    task automatic applyStimulus(input int sel, input bit sm, input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] exp);
        case (sel)
            0: begin bus6.start = 1'b1; bus6.signed_mode = sm; bus6.a = a[5:0]; bus6.b = b[5:0]; q6.push_back(exp); end
            1: begin busu.start = 1'b1; busu.signed_mode = sm; busu.a = a[5:0]; busu.b = b[5:0]; qu.push_back(exp); end
            2: begin bus4.start = 1'b1; bus4.signed_mode = sm; bus4.a = a[3:0]; bus4.b = b[3:0]; q4.push_back(exp); end
            default: begin bus8.start = 1'b1; bus8.signed_mode = sm; bus8.a = a; bus8.b = b; q8.push_back(exp); end
        endcase
        tick();
        bus6.start = 1'b0; busu.start = 1'b0; bus4.start = 1'b0; bus8.start = 1'b0;
        bus6.a = 6'($urandom); bus6.b = 6'($urandom); bus6.signed_mode = ~sm;
        busu.a = 6'($urandom); busu.b = 6'($urandom);
        bus4.a = 4'($urandom); bus4.b = 4'($urandom);
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    endtask

    task automatic waitDone(input int sel, output int cyc);
        cyc = 0;
        while (done_of(sel) !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput("done within budget", 16'(done_of(sel)), 16'd1);
    endtask

    task automatic runOp(input int sel, input bit sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int w);
        int cyc;
        applyStimulus(sel, sm, a, b, exp);
        checkOutput("busy right after accept", 16'(busy_of(sel)), 16'd1);
        waitDone(sel, cyc);
        checkOutput("latency", 16'(cyc), 16'(w));
        checkOutput("ready with done", 16'(ready_of(sel)), 16'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        logic [7:0] ra, rb;
        bit rs;
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        bus6.start = 1'b0; bus6.signed_mode = 1'b0; bus6.a = '0; bus6.b = '0;
        busu.start = 1'b0; busu.signed_mode = 1'b0; busu.a = '0; busu.b = '0;
        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = '0; bus4.b = '0;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;

        // Test 1: reset state, then unsigned 63*63 with cycle-exact busy/done timing.
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        checkOutput("reset ready", 16'(bus6.ready), 16'd1);
        checkOutput("reset busy", 16'(bus6.busy), 16'd0);
        checkOutput("reset done", 16'(bus6.done), 16'd0);
        checkOutput("reset product", 16'(bus6.product), 16'd0);
        applyStimulus(0, 1'b0, 8'd63, 8'd63, 16'hF81);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t1 busy during calc", 16'(bus6.busy), 16'd1);
            checkOutput("t1 ready low during calc", 16'(bus6.ready), 16'd0);
            checkOutput("t1 no early done", 16'(bus6.done), 16'd0);
            tick();
        end
        checkOutput("t1 done after edge k+6", 16'(bus6.done), 16'd1);
        checkOutput("t1 ready with done", 16'(bus6.ready), 16'd1);
        checkOutput("t1 busy low with done", 16'(bus6.busy), 16'd0);
        tick();
        checkOutput("t1 done is one cycle", 16'(bus6.done), 16'd0);
        checkOutput("t1 product held", 16'(bus6.product), 16'hF81);

        // Test 2: signed corners.
        runOp(0, 1'b1, 8'h20, 8'h20, 16'h400, 6);
        runOp(0, 1'b1, 8'h20, 8'h1F, 16'hC20, 6);
        runOp(0, 1'b1, 8'h05, 8'h3D, 16'hFF1, 6);

        // Test 3: zero product, then back-to-back start issued in the done cycle.
        runOp(0, 1'b0, 8'd0, 8'd45, 16'h000, 6);
        runOp(0, 1'b0, 8'd7, 8'd9, 16'd63, 6);

        // Test 4: start pulse and operand changes mid-calculation are ignored.
        applyStimulus(0, 1'b0, 8'd13, 8'd11, 16'd143);
        repeat (3) tick();
        bus6.start = 1'b1; bus6.signed_mode = 1'b1; bus6.a = 6'd1; bus6.b = 6'd1;
        checkOutput("t4 product stable during calc", 16'(bus6.product), 16'd63);
        tick();
        bus6.start = 1'b0; bus6.a = 6'h2A; bus6.b = 6'h15;
        waitDone(0, cyc);
        checkOutput("t4 original latency", 16'(cyc + 4), 16'd6);
        tick();
        checkOutput("t4 single done", 16'(bus6.done), 16'd0);
        checkOutput("t4 back to idle", 16'(bus6.ready), 16'd1);

        // Test 5: asynchronous reset mid-calculation discards the operation.
        applyStimulus(0, 1'b0, 8'd20, 8'd3, 16'd60);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("t5 async ready", 16'(bus6.ready), 16'd1);
        checkOutput("t5 async busy", 16'(bus6.busy), 16'd0);
        checkOutput("t5 async done", 16'(bus6.done), 16'd0);
        checkOutput("t5 async product", 16'(bus6.product), 16'd0);
        q6.delete(); qu.delete(); q4.delete(); q8.delete();
        @(posedge clk);
        #4 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("t5 no done after reset", 16'(bus6.done), 16'd0);
        end
        runOp(0, 1'b1, 8'h39, 8'h06, 16'hFD6, 6);

        // Test 6: signed_mode ignored without signed support; randomised at widths 4, 6, 8.
        runOp(1, 1'b1, 8'h3F, 8'h02, 16'h07E, 6);
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            runOp(1, rs, ra, rb, ref_mul(6, 1'b0, ra, rb), 6);
        end
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            runOp(2, rs, ra, rb, ref_mul(4, rs, ra, rb), 4);
        end
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            runOp(0, rs, ra, rb, ref_mul(6, rs, ra, rb), 6);
        end
        runOp(3, 1'b1, 8'h80, 8'h80, 16'h4000, 8);
        runOp(3, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8);
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            runOp(3, rs, ra, rb, ref_mul(8, rs, ra, rb), 8);
        end

        repeat (3) tick();
        checkOutput("all results delivered", 16'(q6.size() + qu.size() + q4.size() + q8.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
